addsub4_issue_ctrl: RTL
=======================

Name: addsub4_issue_ctrl

Overview:
- Sequencing stage wrapped around the 4-bit adder/subtractor datapath.
- Accepts operation requests (a, b, add/sub) over a valid/ready handshake and buffers them in a small FIFO.
- Drives one operation at a time onto the adder/subtractor inputs from registers, captures its combinational result and flags one cycle later, and presents them downstream over a second valid/ready handshake with backpressure.

Parameters:
WIDTH, 4, operand/result width; must match the adder/subtractor width.
DEPTH, 2, request FIFO entries; power of two, >=2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  request present.
in_ready  output  1  FIFO can accept; equals (count != DEPTH), from registered count only.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_sub  input  1  0 = A+B, 1 = A-B.
au_a  output  WIDTH  registered operand A to the adder/subtractor.
au_b  output  WIDTH  registered operand B to the adder/subtractor.
au_sub  output  1  registered mode to the adder/subtractor.
au_res  input  WIDTH  adder/subtractor result (combinational from au_*).
au_cout  input  1  carry out (for subtract: 1 = no borrow).
au_ovf  input  1  signed overflow.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts.
out_res  output  WIDTH  captured result.
out_cout  output  1  captured carry.
out_ovf  output  1  captured overflow.
out_zero  output  1  captured (au_res == 0).
busy  output  1  high when state != IDLE or FIFO non-empty.

Behaviour:
- Reset (async, any state):
  - FIFO emptied; state = IDLE.
  - au_a = 0, au_b = 0, au_sub = 0.
  - out_valid = 0, out_res = 0, out_cout = 0, out_ovf = 0, out_zero = 0, busy = 0.
  - in_ready = 1 once rst deasserts.
  - Any in-flight or held result is discarded.
- Push: on an edge with in_valid & in_ready, write {in_a, in_b, in_sub} at the write pointer; the pointer wraps modulo DEPTH.
  - When full, in_ready = 0 even if a pop occurs that same cycle; no combinational ready path.
- FSM states IDLE, ISSUE, HOLD:
  - IDLE: if FIFO non-empty, pop head into au_* and go to ISSUE; else stay.
  - ISSUE: au_* are stable for one full cycle. At the next edge, capture au_res, au_cout, au_ovf and (au_res == 0) into the out_* registers, set out_valid = 1, go to HOLD.
  - HOLD: out_* held stable while out_valid & !out_ready.
    - On out_valid & out_ready: if FIFO non-empty (sampled before any same-edge push), pop the next entry into au_*, clear out_valid, go to ISSUE.
    - Otherwise clear out_valid and go to IDLE.
- Latency: request accepted at edge E0 -> au_* loaded at E1 -> out_valid high after E2 (2 cycles).
- Throughput: 1 result per 2 cycles with continuous out_ready.
- Entries issue strictly in FIFO order; none is lost or duplicated under any backpressure.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Pushing into an empty FIFO while in IDLE is seen on the following edge; there is no bypass.
- au_* change only on a pop edge; they are never updated in ISSUE or HOLD without a pop.
- Width rules:
  - No arithmetic inside this block beyond the WIDTH-bit zero compare.
  - Flags pass through unmodified from the adder/subtractor.

Test Plan:
- Reset, then single add a=5, b=3, sub=0; bench adder model attached -> out_valid 2 cycles after accept; res=8, cout=0, ovf=1, zero=0.
- Single sub a=3, b=5, sub=1 -> res=4'b1110, cout=0, ovf=0, zero=0.
  - Then a=7, b=7, sub=1 -> res=0, cout=1, zero=1.
- Hold out_ready=0 and push 3 requests -> in_ready drops after 2 entries are FIFO-held plus 1 in HOLD; out_* stable across 10 cycles.
  - Then release out_ready -> results arrive in order, one every 2 cycles.
- Back-to-back with out_ready=1 and in_valid continuous over 8 requests including a=15, b=1 (res=0, cout=1, zero=1) and a=8, b=1, sub=1 (res=7, ovf=1) -> all 8 correct, in order, with pointer wrap exercised.
- Assert rst during HOLD with a full FIFO -> immediately out_valid=0, busy=0, au_*=0.
  - After release, a new request a=2, b=2 -> res=4, with no stale results emitted.

Source files
------------

// File: rtl/addsub4_issue_ctrl.sv
// ---------------------------------------------------------------------------
// addsub4_issue_ctrl
//
// Sequencing stage in front of a WIDTH-bit adder/subtractor. Requests
// {a, b, sub} are accepted over a valid/ready handshake into a small FIFO.
// One request at a time is popped onto registered operand outputs (au_*).
// The adder/subtractor result is captured one cycle later and held on the
// out_* handshake until the consumer accepts it.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   request present
//   in_ready   out  FIFO has a free entry (registered)
//   in_a/in_b  in   operands, WIDTH bits
//   in_sub     in   0 = a+b, 1 = a-b
//   au_a/au_b  out  registered operands to the adder/subtractor
//   au_sub     out  registered mode to the adder/subtractor
//   au_res     in   adder/subtractor result (combinational from au_*)
//   au_cout    in   carry out (subtract: 1 = no borrow)
//   au_ovf     in   signed overflow
//   out_valid  out  captured result available
//   out_ready  in   consumer accepts
//   out_res    out  captured result
//   out_cout   out  captured carry
//   out_ovf    out  captured overflow
//   out_zero   out  captured (au_res == 0)
//   busy       out  state not IDLE or FIFO non-empty (registered)
// ---------------------------------------------------------------------------
module addsub4_issue_ctrl #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic [WIDTH-1:0] au_a,
   output logic [WIDTH-1:0] au_b,
   output logic             au_sub,
   input  logic [WIDTH-1:0] au_res,
   input  logic             au_cout,
   input  logic             au_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             busy
);

   // Pointer and occupancy widths; the count needs one extra bit to hold DEPTH.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Registered state
   state_t            state_q,    state_d;
   logic [PW-1:0]     wr_ptr_q,   wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]     count_q,    count_d;
   logic [WIDTH-1:0]  mem_a_q   [DEPTH];
   logic [WIDTH-1:0]  mem_a_d   [DEPTH];
   logic [WIDTH-1:0]  mem_b_q   [DEPTH];
   logic [WIDTH-1:0]  mem_b_d   [DEPTH];
   logic              mem_sub_q [DEPTH];
   logic              mem_sub_d [DEPTH];
   logic [WIDTH-1:0]  au_a_q,     au_a_d;
   logic [WIDTH-1:0]  au_b_q,     au_b_d;
   logic              au_sub_q,   au_sub_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_res_q,  out_res_d;
   logic              out_cout_q, out_cout_d;
   logic              out_ovf_q,  out_ovf_d;
   logic              out_zero_q, out_zero_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q,     busy_d;

   // Per-cycle control
   logic              push_s;
   logic              pop_s;
   logic              fifo_empty_s;

   // FSM sequencing: decide whether the FIFO head is popped and capture results.
   always_comb begin
      fifo_empty_s = (count_q == CNT_ZERO);
      push_s       = in_valid & in_ready_q;
      pop_s        = 1'b0;
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_res_d    = out_res_q;
      out_cout_d   = out_cout_q;
      out_ovf_d    = out_ovf_q;
      out_zero_d   = out_zero_q;

      case (state_q)
         ST_IDLE: begin
            // A push seen this edge is not bypassed; it is popped next edge.
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // au_* have been stable for a full cycle; the result is settled.
            out_res_d   = au_res;
            out_cout_d  = au_cout;
            out_ovf_d   = au_ovf;
            out_zero_d  = (au_res == {WIDTH{1'b0}});
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_valid_q & out_ready) begin
               out_valid_d = 1'b0;
               // Emptiness uses the registered count, so a same-edge push waits.
               if (!fifo_empty_s) begin
                  pop_s   = 1'b1;
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Operand registers: loaded only on a pop, otherwise held.
   always_comb begin
      au_a_d   = au_a_q;
      au_b_d   = au_b_q;
      au_sub_d = au_sub_q;
      rd_ptr_d = rd_ptr_q;
      if (pop_s) begin
         au_a_d   = mem_a_q[rd_ptr_q];
         au_b_d   = mem_b_q[rd_ptr_q];
         au_sub_d = mem_sub_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // FIFO write side: store the request at the write pointer, wrap modulo DEPTH.
   always_comb begin
      mem_a_d   = mem_a_q;
      mem_b_d   = mem_b_q;
      mem_sub_d = mem_sub_q;
      wr_ptr_d  = wr_ptr_q;
      if (push_s) begin
         mem_a_d[wr_ptr_q]   = in_a;
         mem_b_d[wr_ptr_q]   = in_b;
         mem_sub_d[wr_ptr_q] = in_sub;
         wr_ptr_d            = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
   end

   // Occupancy and the registered status flags derived from next-state values.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      // in_ready_q always equals (count_q != DEPTH); no combinational path from pop.
      in_ready_d = (count_d != FULL_CNT);
      busy_d     = (state_d != ST_IDLE) | (count_d != CNT_ZERO);
   end

   // State register bank with asynchronous reset; discards any held result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= PTR_ZERO;
         rd_ptr_q    <= PTR_ZERO;
         count_q     <= CNT_ZERO;
         for (int i = 0; i < DEPTH; i++) begin
            mem_a_q[i]   <= {WIDTH{1'b0}};
            mem_b_q[i]   <= {WIDTH{1'b0}};
            mem_sub_q[i] <= 1'b0;
         end
         au_a_q      <= {WIDTH{1'b0}};
         au_b_q      <= {WIDTH{1'b0}};
         au_sub_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_res_q   <= {WIDTH{1'b0}};
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_zero_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mem_a_q     <= mem_a_d;
         mem_b_q     <= mem_b_d;
         mem_sub_q   <= mem_sub_d;
         au_a_q      <= au_a_d;
         au_b_q      <= au_b_d;
         au_sub_q    <= au_sub_d;
         out_valid_q <= out_valid_d;
         out_res_q   <= out_res_d;
         out_cout_q  <= out_cout_d;
         out_ovf_q   <= out_ovf_d;
         out_zero_q  <= out_zero_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign au_a      = au_a_q;
   assign au_b      = au_b_q;
   assign au_sub    = au_sub_q;
   assign out_valid = out_valid_q;
   assign out_res   = out_res_q;
   assign out_cout  = out_cout_q;
   assign out_ovf   = out_ovf_q;
   assign out_zero  = out_zero_q;
   assign busy      = busy_q;

endmodule
